ch_frame_seq: RTL

Frame sequencer placed directly in front of the channel estimator/equalizer. It turns an unframed stream of frequency-domain samples into one framed burst per frame: a single 200-sample long-preamble symbol, then a configurable number of 200-sample data symbols, all under one continuous CYC_O. After each burst it drops CYC_O for a guaranteed gap so the downstream block sees a clean frame-start edge.

---
 rtl/ch_frame_seq.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ch_frame_seq.sv
// ---------------------------------------------------------------------------
// ch_frame_seq
//
// Frame sequencer in front of the channel estimator/equalizer. It frames an
// unframed stream of frequency-domain samples into bursts: one SYM_LEN-sample
// long-preamble symbol followed by NUM_SYM SYM_LEN-sample data symbols, all
// under one continuous CYC_O. After each burst CYC_O is held low for GAP_CYC
// cycles so the downstream block sees a clean frame-start edge.
//
// Ports
//   CLK_I, RST_I          clock (rising edge), asynchronous active-low reset
//   DAT_I[31:0]           input sample, Im[31:16] Re[15:0]
//   WE_I, STB_I, CYC_I    upstream strobes; a sample is offered when all high
//   ACK_O                 sample accepted this cycle (combinational)
//   FRM_START, NUM_SYM    frame request and data-symbol count (used in IDLE)
//   ABORT                 level; ends the current frame early
//   DAT_O, CYC_O, STB_O   registered downstream sample, frame and strobe
//   WE_O                  mirrors CYC_O
//   ACK_I                 downstream accept
//   BUSY                  high in every state except IDLE
//   SYM_IDX[7:0]          0 = preamble, k = k-th data symbol being accepted
//   FRM_DONE, FRM_ABORTED one-cycle end-of-frame pulses
//
// Handshake: upstream transfers when WE_I&STB_I&CYC_I and ACK_O are high in
// the same cycle; downstream transfers when STB_O and ACK_I are high in the
// same cycle. While STB_O is high and ACK_I low (halt), DAT_O/STB_O hold and
// no new sample is accepted.
// ---------------------------------------------------------------------------
module ch_frame_seq #(
    parameter int SYM_LEN = 200,
    parameter int GAP_CYC = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    output logic        ACK_O,
    input  logic        FRM_START,
    input  logic [7:0]  NUM_SYM,
    input  logic        ABORT,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    output logic        BUSY,
    output logic [7:0]  SYM_IDX,
    output logic        FRM_DONE,
    output logic        FRM_ABORTED
);

    localparam logic [7:0] SAMP_LAST = 8'(SYM_LEN - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  samp_cnt_q, samp_cnt_d;
    logic [7:0]  sym_cnt_q, sym_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  nsym_q, nsym_d;
    logic [7:0]  sym_idx_q, sym_idx_d;
    logic        cyc_q, cyc_d;
    logic        aborted_q, aborted_d;
    logic        done_q, done_d;
    logic        abrt_q, abrt_d;
    logic        stb_q;
    logic [31:0] dat_q;

    logic offer;
    logic halt;
    logic ack;
    logic sym_end;

    assign offer   = WE_I & STB_I & CYC_I;
    assign halt    = stb_q & ~ACK_I;
    // ABORT blocks acceptance in the same cycle it is seen.
    assign ack     = offer & ~halt & ~ABORT & ((state_q == S_PRE) || (state_q == S_DATA));
    assign sym_end = ack && (samp_cnt_q == SAMP_LAST);

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        nsym_d     = nsym_q;
        sym_idx_d  = sym_idx_q;
        cyc_d      = cyc_q;
        aborted_d  = aborted_q;
        done_d     = 1'b0;
        abrt_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (FRM_START) begin
                    nsym_d     = NUM_SYM;
                    samp_cnt_d = 8'd0;
                    sym_cnt_d  = 8'd0;
                    aborted_d  = 1'b0;
                    cyc_d      = 1'b1;
                    state_d    = S_PRE;
                end
            end
            S_PRE: begin
                sym_idx_d = 8'd0;
                if (ABORT) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (ack) begin
                    if (sym_end) begin
                        samp_cnt_d = 8'd0;
                        state_d    = (nsym_q != 8'd0) ? S_DATA : S_DRAIN;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 8'd1;
                    end
                end
            end
            S_DATA: begin
                sym_idx_d = sym_cnt_q + 8'd1;
                if (ABORT) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (ack) begin
                    if (sym_end) begin
                        samp_cnt_d = 8'd0;
                        sym_cnt_d  = sym_cnt_q + 8'd1;
                        // sym_cnt counts completed data symbols.
                        if ((sym_cnt_q + 8'd1) == nsym_q) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the last sample is gone or is being taken now,
                // so CYC_O never drops under a pending sample.
                if (!halt) begin
                    cyc_d     = 1'b0;
                    done_d    = ~aborted_q;
                    abrt_d    = aborted_q;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q    <= S_IDLE;
            samp_cnt_q <= 8'd0;
            sym_cnt_q  <= 8'd0;
            gap_cnt_q  <= 8'd0;
            nsym_q     <= 8'd0;
            sym_idx_q  <= 8'd0;
            cyc_q      <= 1'b0;
            aborted_q  <= 1'b0;
            done_q     <= 1'b0;
            abrt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            nsym_q     <= nsym_d;
            sym_idx_q  <= sym_idx_d;
            cyc_q      <= cyc_d;
            aborted_q  <= aborted_d;
            done_q     <= done_d;
            abrt_q     <= abrt_d;
        end
    end

    // Output register: one-cycle latency, holds while halted.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            dat_q <= 32'd0;
            stb_q <= 1'b0;
        end else if (ack) begin
            dat_q <= DAT_I;
            stb_q <= 1'b1;
        end else if (ACK_I) begin
            stb_q <= 1'b0;
        end
    end

    assign ACK_O       = ack;
    assign DAT_O       = dat_q;
    assign STB_O       = stb_q;
    assign CYC_O       = cyc_q;
    assign WE_O        = cyc_q;
    assign BUSY        = (state_q != S_IDLE);
    // PRE/DATA report live; other states hold the last reported index.
    assign SYM_IDX     = sym_idx_d;
    assign FRM_DONE    = done_q;
    assign FRM_ABORTED = abrt_q;

endmodule
